// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator: decodes I/S/B/U/J/Z/SH immediates at XLEN 32/64
// and presents them through a 2-entry skid buffer with valid/ready on both sides.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [2:0] {
    SEL_I   = 3'b000,
    SEL_S   = 3'b001,
    SEL_B   = 3'b010,
    SEL_U   = 3'b011,
    SEL_J   = 3'b100,
    SEL_Z   = 3'b101,
    SEL_SH  = 3'b110,
    SEL_ILL = 3'b111
  } sel_e;

  sel_e  sel;
  xlen_t ext_imm;
  logic  ext_err;

  // The opcode field carries no immediate bits.
  logic unused_opcode;
  assign unused_opcode = ^in_inst[6:0];

  assign sel = sel_e'(in_sel);

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    unique case (sel)
      SEL_I:   ext_imm = xlen_t'($signed(in_inst[31:20]));
      SEL_S:   ext_imm = xlen_t'($signed({in_inst[31:25], in_inst[11:7]}));
      SEL_B:   ext_imm = xlen_t'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                          in_inst[11:8], 1'b0}));
      SEL_U:   ext_imm = xlen_t'($signed({in_inst[31:12], 12'b0}));
      SEL_J:   ext_imm = xlen_t'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                          in_inst[30:21], 1'b0}));
      SEL_Z:   ext_imm = xlen_t'(in_inst[19:15]);
      SEL_SH:  ext_imm = (XLEN == 64) ? xlen_t'(in_inst[25:20]) : xlen_t'(in_inst[24:20]);
      SEL_ILL: ext_err = 1'b1;
      default: ext_err = 1'b1;
    endcase
  end

  logic             m_valid, k_valid;
  xlen_t            m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic             m_err, k_err;
  logic             accept, pop;

  // in_ready comes straight from the skid flop so out_ready never reaches it combinationally.
  assign in_ready  = !k_valid;
  assign accept    = in_valid && in_ready;
  assign pop       = m_valid && out_ready;

  assign out_valid = m_valid;
  assign out_imm   = m_imm;
  assign out_tag   = m_tag;
  assign out_err   = m_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      m_err   <= 1'b0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_err   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (pop && k_valid) begin
      m_imm   <= k_imm;
      m_tag   <= k_tag;
      m_err   <= k_err;
      k_valid <= 1'b0;
    end else if (accept && (pop || !m_valid)) begin
      m_valid <= 1'b1;
      m_imm   <= ext_imm;
      m_tag   <= in_tag;
      m_err   <= ext_err;
    end else if (pop) begin
      m_valid <= 1'b0;
    end else if (accept) begin
      k_valid <= 1'b1;
      k_imm   <= ext_imm;
      k_tag   <= in_tag;
      k_err   <= ext_err;
    end
  end

endmodule
